// File: rtl/hazard_scoreboard_pkg.sv
// Shared core types for the hazard/forwarding unit: register index, latency code,
// forwarding select and the variable-latency marker.
package hazard_scoreboard_pkg;
   localparam int NLANE_DEF = 2;
   localparam int NREG_DEF  = 64;
   localparam int LATW_DEF  = 3;
   localparam int REG_W     = $clog2(NREG_DEF);

   typedef logic [REG_W-1:0]                  reg_idx_t;
   typedef logic [LATW_DEF-1:0]               lat_code_t;
   typedef logic [$clog2(NLANE_DEF+1)-1:0]    fwd_sel_t;

   // All-ones latency code: result time unknown, entry clears only on writeback.
   localparam lat_code_t LAT_VAR = '1;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard register: busy flag plus countdown; flags a hazard while the
// result is more than one cycle away or of unknown latency.
module sb_entry #(
   parameter int LATW = 3
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_set,
   input  logic [LATW-1:0] i_set_lat,
   input  logic            i_wb_hit,
   output logic            o_hazard
);
   logic            r_busy;
   logic [LATW-1:0] r_cnt;
   logic            w_var;

   assign w_var    = &r_cnt;
   assign o_hazard = r_busy & (r_cnt != LATW'(1));

   // A new set takes priority over any same-cycle countdown or writeback clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (i_set) begin
         r_busy <= 1'b1;
         r_cnt  <= i_set_lat;
      end else if (r_busy) begin
         if (w_var) begin
            if (i_wb_hit) begin
               r_busy <= 1'b0;
               r_cnt  <= '0;
            end
         end else if (r_cnt == LATW'(1)) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt - LATW'(1);
         end
      end
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// N-lane hazard/forwarding unit: per-register scoreboard, in-order decode stalls,
// flushes and writeback forwarding selects. Optional perf counters: HAZARD_PERF_EN.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter  int NLANE = NLANE_DEF,
   parameter  int NREG  = NREG_DEF,
   parameter  int LATW  = LATW_DEF,
   localparam int RW    = $clog2(NREG),
   localparam int FW    = $clog2(NLANE+1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NLANE*RW-1:0]   i_rs1_d,
   input  logic [NLANE*RW-1:0]   i_rs2_d,
   input  logic [NLANE*RW-1:0]   i_rd_d,
   input  logic [NLANE-1:0]      i_valid_d,
   input  logic [NLANE*RW-1:0]   i_rs1_e,
   input  logic [NLANE*RW-1:0]   i_rs2_e,
   input  logic [NLANE*RW-1:0]   i_rd_e,
   input  logic [NLANE-1:0]      i_valid_e,
   input  logic [NLANE*LATW-1:0] i_lat_e,
   input  logic [NLANE*RW-1:0]   i_rd_w,
   input  logic [NLANE-1:0]      i_wb_valid,
   input  logic [NLANE-1:0]      i_branch_fail_e,
   output logic                  o_stall_f,
   output logic [NLANE-1:0]      o_stall_d,
   output logic [NLANE-1:0]      o_flush_d,
   output logic [NLANE-1:0]      o_flush_e,
   output logic [NLANE*FW-1:0]   o_fwd_a_e,
   output logic [NLANE*FW-1:0]   o_fwd_b_e
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           o_perf_stall_cnt,
   output logic [31:0]           o_perf_flush_cnt
`endif
);
   logic [NLANE-1:0][RW-1:0]   w_rs1_d, w_rs2_d, w_rd_d, w_rs1_e, w_rs2_e, w_rd_e, w_rd_w;
   logic [NLANE-1:0][LATW-1:0] w_lat_e;
   logic [NLANE-1:0][FW-1:0]   w_fwd_a, w_fwd_b;
   logic [NLANE-1:0]           w_bflush_e, w_pend, w_set_e, w_stall_d, w_flush_e;
   logic                       w_any_bf;
   logic [NREG-1:0]            w_hz;
   logic [NREG-1:1]            w_set_r, w_wb_hit;
   logic [NREG-1:1][LATW-1:0]  w_set_lat;

   assign w_rs1_d = i_rs1_d;
   assign w_rs2_d = i_rs2_d;
   assign w_rd_d  = i_rd_d;
   assign w_rs1_e = i_rs1_e;
   assign w_rs2_e = i_rs2_e;
   assign w_rd_e  = i_rd_e;
   assign w_rd_w  = i_rd_w;
   assign w_lat_e = i_lat_e;

   assign w_hz[0] = 1'b0;
   for (genvar r = 1; r < NREG; r++) begin : g_sb
      sb_entry #(.LATW(LATW)) u_sb (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_set     (w_set_r[r]),
         .i_set_lat (w_set_lat[r]),
         .i_wb_hit  (w_wb_hit[r]),
         .o_hazard  (w_hz[r])
      );
   end

   // Lower-lane misprediction kills every younger execute lane.
   always_comb begin
      logic v_acc;
      v_acc = 1'b0;
      for (int i = 0; i < NLANE; i++) begin
         w_bflush_e[i] = v_acc;
         v_acc         = v_acc | i_branch_fail_e[i];
         w_pend[i]     = i_valid_e[i] & ~w_bflush_e[i] & (w_rd_e[i] != '0) & (w_lat_e[i] != '0);
      end
   end
   assign w_any_bf = |i_branch_fail_e;

   // Pending-set bypass uses only the branch flush so the partial-bundle flush
   // below does not feed back into the hazard it is derived from.
   always_comb begin
      logic                v_stall, v_prev, v_hz;
      logic [2:0][RW-1:0]  v_src;
      v_stall = 1'b0;
      for (int i = 0; i < NLANE; i++) begin
         v_src = {w_rd_d[i], w_rs2_d[i], w_rs1_d[i]};
         v_hz  = 1'b0;
         for (int s = 0; s < 3; s++) begin
            if (v_src[s] != '0) begin
               v_hz = v_hz | w_hz[v_src[s]];
               for (int j = 0; j < NLANE; j++) begin
                  v_hz = v_hz | (w_pend[j] & (w_rd_e[j] == v_src[s]));
                  if (j < i) v_hz = v_hz | (i_valid_d[j] & (w_rd_d[j] == v_src[s]));
               end
            end
         end
         v_prev        = v_stall;
         v_stall       = v_stall | (i_valid_d[i] & v_hz);
         w_stall_d[i]  = v_stall;
         w_flush_e[i]  = w_bflush_e[i];
         if (i != 0) w_flush_e[i] = w_flush_e[i] | (v_stall & ~v_prev);
      end
   end

   assign w_set_e   = w_pend & ~w_flush_e;
   assign o_stall_d = w_stall_d;
   assign o_flush_e = w_flush_e;
   assign o_flush_d = {NLANE{w_any_bf}};
   assign o_stall_f = (|w_stall_d) & ~w_any_bf;

   // Later lanes overwrite earlier ones, so the youngest writer of a register wins.
   always_comb begin
      w_set_r   = '0;
      w_set_lat = '0;
      w_wb_hit  = '0;
      for (int r = 1; r < NREG; r++) begin
         for (int j = 0; j < NLANE; j++) begin
            if (w_set_e[j] && (w_rd_e[j] == RW'(r))) begin
               w_set_r[r]   = 1'b1;
               w_set_lat[r] = w_lat_e[j];
            end
            if (i_wb_valid[j] && (w_rd_w[j] == RW'(r))) w_wb_hit[r] = 1'b1;
         end
      end
   end

   always_comb begin
      w_fwd_a = '0;
      w_fwd_b = '0;
      for (int i = 0; i < NLANE; i++) begin
         for (int j = 0; j < NLANE; j++) begin
            if (i_wb_valid[j] && (w_rd_w[j] != '0)) begin
               if (w_rd_w[j] == w_rs1_e[i]) w_fwd_a[i] = FW'(j+1);
               if (w_rd_w[j] == w_rs2_e[i]) w_fwd_b[i] = FW'(j+1);
            end
         end
      end
   end
   assign o_fwd_a_e = w_fwd_a;
   assign o_fwd_b_e = w_fwd_b;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall, r_perf_flush;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (o_stall_f && !(&r_perf_stall)) r_perf_stall <= r_perf_stall + 32'd1;
         if (w_any_bf  && !(&r_perf_flush)) r_perf_flush <= r_perf_flush + 32'd1;
      end
   end
   assign o_perf_stall_cnt = r_perf_stall;
   assign o_perf_flush_cnt = r_perf_flush;
`endif
endmodule
